// File: rtl/song_sequencer_pkg.sv
// Shared definitions for the song playback path: the sequencer, the song ROM
// and the tone generator all agree on these widths and encodings.
//   NOTE_W / DUR_W / SONG_W : note code, duration (in units) and song number widths
//   NOTE_REST               : note code meaning silence
//   DUR_END                 : duration value that terminates a song
//   seq_state_e             : sequencer FSM state encoding (also exposed for debug)
package song_sequencer_pkg;

  localparam int NOTE_W = 4;
  localparam int DUR_W  = 16;
  localparam int SONG_W = 4;

  localparam logic [NOTE_W-1:0] NOTE_REST = '0;
  localparam logic [DUR_W-1:0]  DUR_END   = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2,
    ST_GAP  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/song_sequencer_tick_gen.sv
// Duration-unit tick generator: a TICK_DIV prescaler that counts 0..TICK_DIV-1
// and raises tick_o for one cycle on the wrap.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : synchronous clear to 0 (dominates enable, suppresses tick)
//   en_i       : count enable; when low the count holds and no tick is produced
//   tick_o     : one-cycle pulse in the cycle the count sits at TICK_DIV-1
module song_sequencer_tick_gen
  import song_sequencer_pkg::*;
#(
  parameter int TICK_DIV = 10000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PS_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt_q;

  assign tick_o = en_i && !clr_i && (cnt_q == PS_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      // Compare-based wrap so non-power-of-two dividers work.
      cnt_q <= (cnt_q == PS_MAX) ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/song_sequencer.sv
// Song playback controller sitting in front of the song ROM. It walks the ROM
// from address 0 of the selected song, holds each note for its duration (in
// TICK_DIV-cycle units), inserts GAP_TICKS silent units between notes, and
// ends on a zero-duration terminator or after the last address.
//   clk, rst_n    : clock, asynchronous active-low reset
//   start, stop   : one-cycle commands; stop wins over everything
//   pause         : level; freezes note/gap timing and mutes note_out
//   song_sel      : song number, captured on an accepted start
//   rom_note      : ROM note for (rom_song, rom_address), combinational
//   rom_duration  : ROM duration in units, 0 = end of song
//   rom_address   : registered ROM address
//   rom_song      : captured song number driven to the ROM
//   note_out      : note to the tone generator, 0 = silence
//   playing       : high in LOAD, PLAY and GAP
//   done          : one-cycle pulse on a natural end of song
//   state_dbg     : current FSM state
module song_sequencer
  import song_sequencer_pkg::*;
#(
  parameter int TICK_DIV  = 10000,
  parameter int GAP_TICKS = 20,
  parameter int ADDR_W    = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic [SONG_W-1:0] song_sel,
  input  logic [NOTE_W-1:0] rom_note,
  input  logic [DUR_W-1:0]  rom_duration,
  output logic [ADDR_W-1:0] rom_address,
  output logic [SONG_W-1:0] rom_song,
  output logic [NOTE_W-1:0] note_out,
  output logic              playing,
  output logic              done,
  output seq_state_e        state_dbg
);

  // A zero-width gap counter is impossible, so legato builds keep one bit.
  localparam int GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
  localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(GAP_TICKS);
  localparam logic [GAP_W-1:0]  GAP_ONE   = GAP_W'(1);
  localparam logic [DUR_W-1:0]  DUR_ONE   = DUR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  seq_state_e        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [SONG_W-1:0] song_q;
  logic [NOTE_W-1:0] note_q;
  logic [DUR_W-1:0]  dur_cnt_q;
  logic [GAP_W-1:0]  gap_cnt_q;
  logic              done_q;
  logic              tick;
  logic              presc_clr;

  // Keep the prescaler at 0 outside PLAY/GAP so each note starts on a full unit.
  assign presc_clr = stop || (state_q == ST_IDLE) || (state_q == ST_LOAD);

  song_sequencer_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (presc_clr),
    .en_i   (!pause),
    .tick_o (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      song_q    <= '0;
      note_q    <= NOTE_REST;
      dur_cnt_q <= '0;
      gap_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (stop) begin
        state_q <= ST_IDLE;
        addr_q  <= '0;
        note_q  <= NOTE_REST;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            // A start landing on the done cycle is dropped; it must be re-pulsed.
            if (start && !done_q) begin
              addr_q  <= '0;
              song_q  <= song_sel;
              state_q <= ST_LOAD;
            end
          end
          ST_LOAD: begin
            // The ROM has had this cycle to settle; sample unless paused.
            if (!pause) begin
              if (rom_duration == DUR_END) begin
                state_q <= ST_IDLE;
                done_q  <= 1'b1;
                note_q  <= NOTE_REST;
              end else begin
                dur_cnt_q <= rom_duration;
                note_q    <= rom_note;
                state_q   <= ST_PLAY;
              end
            end
          end
          ST_PLAY: begin
            if (tick) begin
              dur_cnt_q <= dur_cnt_q - 1'b1;
              if (dur_cnt_q == DUR_ONE) begin
                if (GAP_TICKS > 0) begin
                  note_q    <= NOTE_REST;
                  gap_cnt_q <= GAP_LOAD;
                  state_q   <= ST_GAP;
                end else if (addr_q == ADDR_LAST) begin
                  state_q <= ST_IDLE;
                  done_q  <= 1'b1;
                  note_q  <= NOTE_REST;
                end else begin
                  // Legato: the old note keeps sounding through LOAD.
                  addr_q  <= addr_q + 1'b1;
                  state_q <= ST_LOAD;
                end
              end
            end
          end
          ST_GAP: begin
            if (tick) begin
              gap_cnt_q <= gap_cnt_q - 1'b1;
              if (gap_cnt_q == GAP_ONE) begin
                // The last address ends the song rather than wrapping to 0.
                if (addr_q == ADDR_LAST) begin
                  state_q <= ST_IDLE;
                  done_q  <= 1'b1;
                end else begin
                  addr_q  <= addr_q + 1'b1;
                  state_q <= ST_LOAD;
                end
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign rom_address = addr_q;
  assign rom_song    = song_q;
  // Pause mutes immediately; the held note returns as soon as pause drops.
  assign note_out    = pause ? NOTE_REST : note_q;
  assign playing     = (state_q != ST_IDLE);
  assign done        = done_q;
  assign state_dbg   = state_q;

endmodule
